// File: rtl/rtl_kernel_wizard_0_example_pkg.sv
// Shared types and constants for the example AXI read master.
package rtl_kernel_wizard_0_example_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned MAX_BURST_BEATS   = 64;
   localparam int unsigned BOUNDARY_4K_BYTES = 4096;

endpackage

// File: rtl/rtl_kernel_wizard_0_example_counter.sv
// Up/down occupancy counter with a saturation flag; inc and dec together cancel.
module rtl_kernel_wizard_0_example_counter #(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned MAX_VALUE = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic is_max_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i) begin
         count_d = count_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign is_max_o = (count_q == WIDTH'(MAX_VALUE));

endmodule

// File: rtl/rtl_kernel_wizard_0_example_axi_read_master.sv
// AXI4 read master: splits a byte transfer into 4 KiB-safe bursts and streams the data out.
module rtl_kernel_wizard_0_example_axi_read_master
   import rtl_kernel_wizard_0_example_pkg::*;
#(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
   parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
   parameter int unsigned C_MAX_OUTSTANDING  = 16
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          ctrl_start,
   output logic                          ctrl_done,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                    m_axi_arlen,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic                          m_axi_rlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                          m_axis_tlast
);

   localparam int unsigned AW       = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned XW       = C_XFER_SIZE_WIDTH;
   localparam int unsigned BPB      = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned LOG2_BPB = $clog2(BPB);
   localparam int unsigned CMP_W    = (XW > 14) ? XW : 14;
   localparam int unsigned CNT_W    = $clog2(C_MAX_OUTSTANDING + 1);
   localparam logic [AW-1:0] ALIGN_MASK = AW'(BPB - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [XW-1:0]    ar_rem_q, ar_rem_d;
   logic [XW-1:0]    total_q, total_d;
   logic [XW-1:0]    rx_cnt_q, rx_cnt_d;
   logic [XW-1:0]    req_beats;
   logic [12:0]      bound_bytes;
   logic [CMP_W-1:0] bound_beats, burst_beats;
   logic             run, os_full, ar_hs, r_hs, t_hs;

   assign req_beats   = (ctrl_xfer_size_in_bytes >> LOG2_BPB)
                      + XW'(|ctrl_xfer_size_in_bytes[LOG2_BPB-1:0]);
   assign bound_bytes = 13'(BOUNDARY_4K_BYTES) - {1'b0, addr_q[11:0]};
   assign bound_beats = CMP_W'(bound_bytes >> LOG2_BPB);

   always_comb begin
      burst_beats = CMP_W'(MAX_BURST_BEATS);
      if (bound_beats < burst_beats) burst_beats = bound_beats;
      if (CMP_W'(ar_rem_q) < burst_beats) burst_beats = CMP_W'(ar_rem_q);
   end

   // AR is driven straight from registered address/remaining; both only move on
   // a handshake and is_max only rises on a handshake, so a pending AR is stable.
   assign run           = (state_q == ST_RUN);
   assign m_axi_arvalid = run && (ar_rem_q != '0) && !os_full;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = 8'(burst_beats - 1'b1);
   assign m_axi_rready  = m_axis_tready & run;
   assign m_axis_tvalid = m_axi_rvalid & run;
   assign m_axis_tdata  = m_axi_rdata;
   assign m_axis_tlast  = m_axis_tvalid && (rx_cnt_q == total_q - 1'b1);
   assign ctrl_done     = (state_q == ST_DONE);

   assign ar_hs = m_axi_arvalid & m_axi_arready;
   assign r_hs  = m_axi_rvalid & m_axi_rready;
   assign t_hs  = m_axis_tvalid & m_axis_tready;

   rtl_kernel_wizard_0_example_counter #(
      .WIDTH     (CNT_W),
      .MAX_VALUE (C_MAX_OUTSTANDING)
   ) u_outstanding (
      .clk_i    (aclk),
      .rst_i    (areset),
      .inc_i    (ar_hs),
      .dec_i    (r_hs & m_axi_rlast),
      .is_max_o (os_full)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      ar_rem_d = ar_rem_q;
      total_d  = total_q;
      rx_cnt_d = rx_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_start) begin
               addr_d   = ctrl_addr_offset & ~ALIGN_MASK;
               total_d  = req_beats;
               ar_rem_d = req_beats;
               rx_cnt_d = '0;
               state_d  = (req_beats == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (ar_hs) begin
               addr_d   = addr_q + (AW'(burst_beats) << LOG2_BPB);
               ar_rem_d = ar_rem_q - XW'(burst_beats);
            end
            if (t_hs) begin
               rx_cnt_d = rx_cnt_q + 1'b1;
               if (m_axis_tlast) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         ar_rem_q <= '0;
         total_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         ar_rem_q <= ar_rem_d;
         total_q  <= total_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

endmodule

// File: tb/tb_rtl_kernel_wizard_0_example_axi_read_master.sv
// Bench for the AXI read master: transaction-level model, AXI slave responder, directed cases.
module tb_rtl_kernel_wizard_0_example_axi_read_master;

   localparam int MAXO = 16;

   logic         aclk = 1'b0;
   logic         areset = 1'b1;
   logic         ctrl_start = 1'b0;
   logic         ctrl_done;
   logic [63:0]  ctrl_addr_offset = '0;
   logic [31:0]  ctrl_xfer_size_in_bytes = '0;
   logic         m_axi_arvalid;
   logic         m_axi_arready = 1'b1;
   logic [63:0]  m_axi_araddr;
   logic [7:0]   m_axi_arlen;
   logic         m_axi_rvalid = 1'b0;
   logic         m_axi_rready;
   logic [511:0] m_axi_rdata = '0;
   logic         m_axi_rlast = 1'b0;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b1;
   logic [511:0] m_axis_tdata;
   logic         m_axis_tlast;

   rtl_kernel_wizard_0_example_axi_read_master #(
      .C_M_AXI_ADDR_WIDTH (64),
      .C_M_AXI_DATA_WIDTH (512),
      .C_XFER_SIZE_WIDTH  (32),
      .C_MAX_OUTSTANDING  (MAXO)
   ) dut (
      .aclk                    (aclk),
      .areset                  (areset),
      .ctrl_start              (ctrl_start),
      .ctrl_done               (ctrl_done),
      .ctrl_addr_offset        (ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
      .m_axi_arvalid           (m_axi_arvalid),
      .m_axi_arready           (m_axi_arready),
      .m_axi_araddr            (m_axi_araddr),
      .m_axi_arlen             (m_axi_arlen),
      .m_axi_rvalid            (m_axi_rvalid),
      .m_axi_rready            (m_axi_rready),
      .m_axi_rdata             (m_axi_rdata),
      .m_axi_rlast             (m_axi_rlast),
      .m_axis_tvalid           (m_axis_tvalid),
      .m_axis_tready           (m_axis_tready),
      .m_axis_tdata            (m_axis_tdata),
      .m_axis_tlast            (m_axis_tlast)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [63:0] addr;
      int          len;
   } ar_t;

   int  n_vec = 0, n_err = 0;
   int  m_phase = 0;            // 0 idle, 1 running, 2 done cycle
   int  m_total = 0, m_rx = 0, m_os = 0;
   logic [63:0] m_base = '0;
   ar_t exp_ar[$], ar_log[$], slv_q[$];
   int  slv_beat = 0;
   bit  r_stall = 0, ar_rand = 0, t_rand = 0, t_fix = 1;
   int  cyc = 0, done_count = 0, start_cyc = -1, done_cyc = -1, last_tlast_beat = 0;
   bit  rlast_seen = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_w(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got low 0x%0h, want low 0x%0h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
      end
   endtask

   function automatic logic [511:0] pat(input logic [63:0] a);
      return {8{a ^ 64'h5A5A_0000_C3C3_0000}};
   endfunction

   // Expected bursts straight from the rules: min(remaining, 64, beats to next 4 KiB).
   task automatic build_model(input logic [63:0] addr, input longint size);
      logic [63:0] a;
      longint rem, n, to_b;
      m_base  = addr & ~64'h3F;
      m_total = int'((size + 63) / 64);
      exp_ar.delete();
      a   = m_base;
      rem = m_total;
      while (rem > 0) begin
         to_b = (4096 - longint'(a[11:0])) / 64;
         n = rem;
         if (n > 64) n = 64;
         if (n > to_b) n = to_b;
         exp_ar.push_back('{a, int'(n) - 1});
         a   = a + 64'(n * 64);
         rem = rem - n;
      end
   endtask

   // Compare + slave process: sample and check at negedge, update model and drive after posedge.
   initial begin
      bit ar_hs, r_hs, t_hs, s_start, s_rst, s_rlast, t_end, allowed, prev_wait;
      logic [63:0] prev_addr, s_addr, s_off;
      logic [7:0]  prev_len, s_len;
      logic [31:0] s_size;
      prev_wait = 0; prev_addr = '0; prev_len = '0;
      forever begin
         @(negedge aclk);
         cyc++;
         ar_hs   = m_axi_arvalid & m_axi_arready;
         r_hs    = m_axi_rvalid & m_axi_rready;
         t_hs    = m_axis_tvalid & m_axis_tready;
         s_rlast = m_axi_rlast;
         s_start = ctrl_start;
         s_rst   = areset;
         s_off   = ctrl_addr_offset;
         s_size  = ctrl_xfer_size_in_bytes;
         s_addr  = m_axi_araddr;
         s_len   = m_axi_arlen;
         t_end   = t_hs && (m_rx + 1 == m_total);

         check("tvalid", 64'(m_axis_tvalid), 64'(m_axi_rvalid && m_phase == 1));
         check("rready", 64'(m_axi_rready), 64'(m_axis_tready && m_phase == 1));
         check("ctrl_done", 64'(ctrl_done), 64'(m_phase == 2));
         check("tlast", 64'(m_axis_tlast), 64'(m_axis_tvalid && m_phase == 1 && (m_rx + 1 == m_total)));
         if (m_axis_tvalid) check_w("tdata_pass", m_axis_tdata, m_axi_rdata);
         if (t_hs) check_w("beat_data", m_axis_tdata, pat(m_base + 64'(m_rx) * 64));
         allowed = (m_phase == 1) && (m_os < MAXO) && (exp_ar.size() > 0);
         check("arvalid_gate", 64'(m_axi_arvalid & ~allowed), 64'd0);
         if (prev_wait) begin
            check("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
            check("ar_hold_addr", m_axi_araddr, prev_addr);
            check("ar_hold_len", 64'(m_axi_arlen), 64'(prev_len));
         end
         if (ar_hs) begin
            if (exp_ar.size() == 0) begin
               check("ar_extra", 64'd1, 64'd0);
            end else begin
               ar_t e;
               e = exp_ar.pop_front();
               check("araddr", m_axi_araddr, e.addr);
               check("arlen", 64'(m_axi_arlen), 64'(e.len));
            end
            ar_log.push_back('{m_axi_araddr, int'(m_axi_arlen)});
         end
         prev_wait = m_axi_arvalid & ~m_axi_arready;
         prev_addr = m_axi_araddr;
         prev_len  = m_axi_arlen;
         if (ctrl_done) begin
            done_count++;
            done_cyc = cyc;
         end
         if (t_hs && m_axis_tlast) last_tlast_beat = m_rx + 1;
         if (r_hs && s_rlast) rlast_seen = 1;

         @(posedge aclk);
         #1;
         if (s_rst) begin
            m_phase = 0; m_rx = 0; m_os = 0;
            exp_ar.delete(); slv_q.delete(); slv_beat = 0; prev_wait = 0;
         end else begin
            m_os = m_os + int'(ar_hs) - int'(r_hs && s_rlast);
            if (t_hs) m_rx++;
            case (m_phase)
               0: if (s_start) begin
                     build_model(s_off, longint'(s_size));
                     start_cyc = cyc;
                     ar_log.delete();
                     m_rx = 0;
                     m_phase = (m_total == 0) ? 2 : 1;
                  end
               1: if (t_end) m_phase = 2;
               default: m_phase = 0;
            endcase
            if (ar_hs) slv_q.push_back('{s_addr, int'(s_len)});
            if (r_hs && slv_q.size() > 0) begin
               if (slv_beat == slv_q[0].len) begin
                  void'(slv_q.pop_front());
                  slv_beat = 0;
               end else begin
                  slv_beat++;
               end
            end
         end
         m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axis_tready = t_rand ? 1'($urandom_range(0, 1)) : t_fix;
         if (!r_stall && slv_q.size() > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = pat(slv_q[0].addr + 64'(slv_beat) * 64);
            m_axi_rlast  = (slv_beat == slv_q[0].len);
         end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
         end
      end
   end

   task automatic do_start(input logic [63:0] a, input logic [31:0] s);
      ctrl_addr_offset        = a;
      ctrl_xfer_size_in_bytes = s;
      ctrl_start              = 1'b1;
      @(posedge aclk); #2;
      ctrl_start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string nm);
      int d0, i;
      d0 = done_count;
      i  = 0;
      while (done_count == d0 && i < maxc) begin
         @(posedge aclk); #2;
         i++;
      end
      if (done_count == d0) begin
         n_vec++; n_err++;
         $display("FAIL %s: ctrl_done not seen within %0d cycles", nm, maxc);
      end
   endtask

   task automatic idle_outputs(input string nm);
      check({nm, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
      check({nm, "_rready"}, 64'(m_axi_rready), 64'd0);
      check({nm, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({nm, "_tlast"}, 64'(m_axis_tlast), 64'd0);
      check({nm, "_done"}, 64'(ctrl_done), 64'd0);
   endtask

   initial begin
      int d0, i;
      logic [63:0] t1_addr [4];
      t1_addr = '{64'h0, 64'h1000, 64'h2000, 64'h3000};

      repeat (3) @(posedge aclk);
      #2 areset = 1'b0;
      @(negedge aclk);
      idle_outputs("reset");
      @(posedge aclk); #2;

      // 16 KiB from 0: four full bursts on 4 KiB boundaries
      d0 = done_count;
      do_start(64'h0, 32'd16384);
      wait_done(3000, "t1_done");
      check("t1_ar_count", 64'(ar_log.size()), 64'd4);
      for (int k = 0; k < 4 && k < ar_log.size(); k++) begin
         check("t1_ar_addr", ar_log[k].addr, t1_addr[k]);
         check("t1_ar_len", 64'(ar_log[k].len), 64'd63);
      end
      check("t1_tlast_beat", 64'(last_tlast_beat), 64'd256);
      repeat (3) @(posedge aclk); #2;
      check("t1_done_once", 64'(done_count - d0), 64'd1);

      // Straddling a 4 KiB boundary
      do_start(64'hFC0, 32'd192);
      wait_done(500, "t2_done");
      check("t2_ar_count", 64'(ar_log.size()), 64'd2);
      if (ar_log.size() == 2) begin
         check("t2_ar0_addr", ar_log[0].addr, 64'hFC0);
         check("t2_ar0_len", 64'(ar_log[0].len), 64'd0);
         check("t2_ar1_addr", ar_log[1].addr, 64'h1000);
         check("t2_ar1_len", 64'(ar_log[1].len), 64'd1);
      end
      check("t2_tlast_beat", 64'(last_tlast_beat), 64'd3);

      // Zero-length, started in the cycle right after the previous done
      do_start(64'h1234, 32'd0);
      wait_done(20, "t3_done");
      check("t3_done_latency", 64'(done_cyc - start_cyc), 64'd1);
      check("t3_ar_count", 64'(ar_log.size()), 64'd0);

      // 70 bytes round up to 2 beats, high address bits preserved
      do_start(64'h1_0000_0000, 32'd70);
      wait_done(200, "t4_done");
      check("t4_ar_count", 64'(ar_log.size()), 64'd1);
      if (ar_log.size() == 1) begin
         check("t4_ar_addr", ar_log[0].addr, 64'h1_0000_0000);
         check("t4_ar_len", 64'(ar_log[0].len), 64'd1);
      end
      check("t4_tlast_beat", 64'(last_tlast_beat), 64'd2);

      // Outstanding limit with R stalled, then abandon by reset
      r_stall = 1;
      d0 = done_count;
      do_start(64'h0, 32'd1048576);
      repeat (40) @(posedge aclk); #2;
      check("t5_ar_count", 64'(ar_log.size()), 64'd16);
      @(negedge aclk);
      check("t5_arvalid_low", 64'(m_axi_arvalid), 64'd0);
      @(posedge aclk); #2;
      rlast_seen = 0;
      r_stall = 0;
      i = 0;
      while (!rlast_seen && i < 300) begin
         @(posedge aclk); #2;
         i++;
      end
      check("t5_rlast_seen", 64'(rlast_seen), 64'd1);
      @(negedge aclk);
      check("t5_arvalid_reassert", 64'(m_axi_arvalid), 64'd1);
      @(posedge aclk); #2 areset = 1'b1;
      @(posedge aclk); #2 areset = 1'b0;
      @(negedge aclk);
      idle_outputs("t5_reset");
      repeat (10) @(posedge aclk); #2;
      check("t5_no_done", 64'(done_count - d0), 64'd0);

      // Random backpressure on AR and stream, ignored second start
      ar_rand = 1; t_rand = 1;
      d0 = done_count;
      do_start(64'h2040, 32'd19200);
      repeat (30) @(posedge aclk); #2;
      do_start(64'h0, 32'd64);
      wait_done(5000, "t6_done");
      check("t6_ar_count", 64'(ar_log.size()), 64'd5);
      if (ar_log.size() == 5) begin
         check("t6_ar0_addr", ar_log[0].addr, 64'h2040);
         check("t6_ar0_len", 64'(ar_log[0].len), 64'd62);
         check("t6_ar4_addr", ar_log[4].addr, 64'h6000);
         check("t6_ar4_len", 64'(ar_log[4].len), 64'd44);
      end
      check("t6_tlast_beat", 64'(last_tlast_beat), 64'd300);
      repeat (5) @(posedge aclk); #2;
      check("t6_done_once", 64'(done_count - d0), 64'd1);
      ar_rand = 0; t_rand = 0; t_fix = 1;

      // Reset at beat 100
      d0 = done_count;
      do_start(64'h8000, 32'd12800);
      i = 0;
      while (m_rx < 100 && i < 1000) begin
         @(posedge aclk); #2;
         i++;
      end
      check("t7_reached_100", 64'(m_rx >= 100), 64'd1);
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      idle_outputs("t7_reset");
      @(posedge aclk); #2 areset = 1'b0;
      repeat (20) @(posedge aclk); #2;
      check("t7_no_done", 64'(done_count - d0), 64'd0);

      // Fresh transfer after reset
      do_start(64'h40, 32'd128);
      wait_done(200, "t8_done");
      check("t8_ar_count", 64'(ar_log.size()), 64'd1);
      if (ar_log.size() == 1) begin
         check("t8_ar_addr", ar_log[0].addr, 64'h40);
         check("t8_ar_len", 64'(ar_log[0].len), 64'd1);
      end
      check("t8_tlast_beat", 64'(last_tlast_beat), 64'd2);

      repeat (3) @(posedge aclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
